math_divider_8bit_seq: RTL
==========================

Name: math_divider_8bit_seq

Overview:
- Iterative restoring divider for the FSM calculator datapath, one quotient bit per clock.
- Does no subtraction itself. Each cycle it drives the ripple-borrow 8-bit subtractor next to it (sub_a, sub_b, sub_borrow_in) and consumes that subtractor's diff and borrow/error result.
- Sits between the operand registers and the result display mux. Produces quotient, remainder and a divide-by-zero error.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 to match the subtractor; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  one-cycle request; sampled only in IDLE
- a  input  8  dividend (unsigned)
- b  input  8  divisor (unsigned)
- sub_a  output  8  minuend to subtractor
- sub_b  output  8  subtrahend to subtractor
- sub_borrow_in  output  1  borrow-in to subtractor; constant 0
- sub_diff  input  8  difference from subtractor
- sub_error  input  1  borrow-out from subtractor (1 = sub_a < sub_b)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when results are valid
- quotient  output  8  result, held until next accepted start
- remainder  output  8  result, held until next accepted start
- div_zero  output  1  high with done when b==0; held with the results

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state=IDLE; busy, done, div_zero = 0; quotient, remainder, sub_a, sub_b = 8'h00; sub_borrow_in = 0; internal count=0.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.
- States:
  - IDLE: on start=1, latch a->dvd, b->dvs, clear R, Q, div_zero. Go to CHECK. busy rises next cycle.
  - CHECK: if dvs==0, set div_zero=1, quotient=8'hFF, remainder=dvd, go to DONE. Otherwise count=7, go to ITER.
  - ITER (8 cycles, count 7 down to 0):
    - Form T = {R[6:0], dvd[count]}.
    - Drive sub_a=T, sub_b=dvs combinationally from the current registers; sub_borrow_in=0.
    - Same edge: if sub_error==0, then R<=sub_diff and Q[count]<=1; else R<=T and Q[count]<=0.
    - At count==0, go to DONE; otherwise count decrements.
  - DONE: one cycle. done=1, busy=0. quotient/remainder show Q/R (or the div_zero values). Go to IDLE.
- Subtractor loop is combinational within one cycle (subtractor is purely combinational). No extra pipeline stage.
- Width: T never exceeds 8 bits, because R < dvs and R ≤ the processed prefix of dvd. No 9th bit is needed.
- Latency: start sampled at edge 0. CHECK at edge 1, ITER at edges 2..9. done is high in the cycle after edge 10 (10 cycles). Divide-by-zero: done after edge 2.
- start while busy or in DONE is ignored; there is no queue.
- a/b may change after the accepting edge without effect.
- Outside ITER, sub_a/sub_b hold 8'h00.

Optional Feature:
- Macro: MATH_DIVIDER_EARLY_EXIT_EN.
- Defined:
  - In CHECK with dvs!=0, drive sub_a=dvd, sub_b=dvs.
  - If sub_error==1 (a<b), set quotient=0, remainder=dvd, go directly to DONE. done is high after edge 2.
  - If sub_error==0, proceed normally.
- Not defined: CHECK never drives the subtractor, and every non-zero divisor takes the full 8 iterations.

Test Plan:
- a=200, b=7, start pulse -> 10 cycles later done=1, quotient=28, remainder=4, div_zero=0; busy high for exactly 9 cycles.
- a=255, b=1 -> quotient=255, remainder=0. Then a=0, b=9 -> quotient=0, remainder=0. With MATH_DIVIDER_EARLY_EXIT_EN: done 2 cycles after start.
- a=5, b=0 -> done 2 cycles after start, div_zero=1, quotient=8'hFF, remainder=5. A following 9/3 clears div_zero and gives quotient=3, remainder=0.
- a=13, b=20 -> quotient=0, remainder=13. Without the macro: 10-cycle latency; with it: 2-cycle latency.
- Start 100/9, pulse start again with 50/5 at cycle 4 -> second start ignored; result quotient=11, remainder=1.
- Start 100/9, assert reset at cycle 5 -> all outputs 0 immediately, no done pulse. A new start afterwards completes normally.
- Randomised check (all 65536 a/b pairs) against the reference model: quotient=a/b, remainder=a%b; b==0 per the div_zero rule.

Source files
------------

// File: rtl/math_divider_8bit_seq.sv
// Iterative restoring divider, one quotient bit per clock, driving an external
// combinational subtractor. Define MATH_DIVIDER_EARLY_EXIT_EN to finish early when a < b.
module math_divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_borrow_in,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_error,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_zero_q, div_zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   trial;

  // Partial remainder shifted left with the next dividend bit; R stays below
  // the processed dividend prefix, so the dropped R msb is always zero here.
  assign trial = {r_q[WIDTH-2:0], dvd_q[cnt_q]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    sub_a      = '0;
    sub_b      = '0;

    unique case (state_q)
      S_IDLE: begin
        // The done cycle is still part of the previous operation, so a start there is dropped.
        if (start && !done_q) begin
          dvd_d      = a;
          dvs_d      = b;
          r_d        = '0;
          q_d        = '0;
          div_zero_d = 1'b0;
          state_d    = S_CHECK;
        end
      end

      S_CHECK: begin
        if (dvs_q == '0) begin
          div_zero_d = 1'b1;
          q_d        = '1;
          r_d        = dvd_q;
          state_d    = S_DONE;
        end else begin
`ifdef MATH_DIVIDER_EARLY_EXIT_EN
          sub_a = dvd_q;
          sub_b = dvs_q;
          if (sub_error) begin
            q_d     = '0;
            r_d     = dvd_q;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = S_ITER;
          end
`else
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_ITER;
`endif
        end
      end

      S_ITER: begin
        sub_a = trial;
        sub_b = dvs_q;
        if (!sub_error) begin
          r_d        = sub_diff;
          q_d[cnt_q] = 1'b1;
        end else begin
          r_d        = trial;
          q_d[cnt_q] = 1'b0;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags trail the state by one cycle, so busy covers exactly the
  // CHECK and ITER cycles and done pulses once after DONE.
  assign busy_d = (state_q == S_CHECK) || (state_q == S_ITER);
  assign done_d = (state_q == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sub_borrow_in = 1'b0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign quotient      = q_q;
  assign remainder     = r_q;
  assign div_zero      = div_zero_q;

endmodule
